mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 38 +++
 rtl/mem_arb_starve_ctr.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types for the CPU/PDU memory bus arbiter.
// FSM state enum, command bundle, MMIO page default and field widths.
package mem_bus_arbiter_pkg;

  localparam logic [7:0] MMIO_PAGE_DEF = 8'h7f;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RT_W = 3;
  localparam int WT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_PDU = 1'b1
  } port_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [RT_W-1:0] rt;
    logic [WT_W-1:0] wt;
  } cmd_t;

  function automatic logic is_mmio(
    input logic [AW-1:0] a,
    input logic [7:0]    page
  );
    return a[15:8] == page;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts port-0 grants while port 1 waits.
// Ports: clk, rst, grant0, grant1, m1_req, clear -> starved.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant0,
  input  logic grant1,
  input  logic m1_req,
  input  logic clear,
  output logic starved
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat   = (r_cnt >= MAXV);
  assign starved = w_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || grant1) begin
      r_cnt <= '0;
    end else if (grant0 && m1_req && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (CPU=0, PDU=1) arbiter onto one MEM/MMIO bus.
// Ports: mN_* requester side, mem_*/dm_we/mmio_we bus side, busy status.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [7:0] MMIO_PAGE  = MMIO_PAGE_DEF,
  parameter int         STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [RT_W-1:0] m0_read_type,
  input  logic [WT_W-1:0] m0_write_type,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [RT_W-1:0] m1_read_type,
  input  logic [WT_W-1:0] m1_write_type,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic [RT_W-1:0] mem_read_type,
  output logic [WT_W-1:0] mem_write_type,
  output logic            dm_we,
  output logic            mmio_we,
  input  logic [DW-1:0]   dm_dout,
  input  logic [DW-1:0]   mmio_dout,

  output logic            busy
);

  state_t  r_state;
  state_t  w_next;
  cmd_t    r_cmd;
  port_t   r_win;

  cmd_t    w_cmd0;
  cmd_t    w_cmd1;
  cmd_t    w_pick_cmd;
  logic    w_take;
  logic    w_pick1;
  logic    w_starved;
  logic    w_mmio;
  logic    w_clr;

  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_dm_we;
  logic    w_mmio_we;
  logic    w_rv0;
  logic    w_rv1;
  logic [DW-1:0] w_rdata;

  assign w_cmd0 = '{
    we:    m0_we,
    addr:  m0_addr,
    wdata: m0_wdata,
    rt:    m0_read_type,
    wt:    m0_write_type
  };

  assign w_cmd1 = '{
    we:    m1_we,
    addr:  m1_addr,
    wdata: m1_wdata,
    rt:    m1_read_type,
    wt:    m1_write_type
  };

  // Port 0 wins unless starved; port 1 only takes over when it asks.
  assign w_take     = (r_state == S_IDLE) && (m0_req || m1_req);
  assign w_pick1    = m1_req && !(m0_req && !w_starved);
  assign w_pick_cmd = w_pick1 ? w_cmd1 : w_cmd0;

  assign w_mmio  = is_mmio(r_cmd.addr, MMIO_PAGE);
  assign w_rdata = w_mmio ? mmio_dout : dm_dout;

  // Port 1 not waiting while idle resets its starvation history.
  assign w_clr = (r_state == S_IDLE) && !m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_win   <= PORT_CPU;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_cmd <= w_pick_cmd;
        r_win <= w_pick1 ? PORT_PDU : PORT_CPU;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_dm_we   = 1'b0;
    w_mmio_we = 1'b0;
    w_rv0     = 1'b0;
    w_rv1     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_gnt0 = (r_win == PORT_CPU);
        w_gnt1 = (r_win == PORT_PDU);
        if (r_cmd.we) begin
          w_dm_we   = !w_mmio;
          w_mmio_we = w_mmio;
          w_next    = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rv0  = (r_win == PORT_CPU);
        w_rv1  = (r_win == PORT_PDU);
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // The state register still holds the old state while rst is high;
    // squash every strobe so a reset in ISSUE/RESP has no side effects.
    if (rst) begin
      w_gnt0    = 1'b0;
      w_gnt1    = 1'b0;
      w_dm_we   = 1'b0;
      w_mmio_we = 1'b0;
      w_rv0     = 1'b0;
      w_rv1     = 1'b0;
    end
  end

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .grant0  (w_gnt0),
    .grant1  (w_gnt1),
    .m1_req  (m1_req),
    .clear   (w_clr),
    .starved (w_starved)
  );

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = w_rv0;
  assign m1_rvalid = w_rv1;
  assign m0_rdata  = w_rv0 ? w_rdata : '0;
  assign m1_rdata  = w_rv1 ? w_rdata : '0;

  assign dm_we   = w_dm_we;
  assign mmio_we = w_mmio_we;

  // Bus holds the last latched command; forced to 0 while in reset.
  assign mem_addr       = rst ? '0 : r_cmd.addr;
  assign mem_din        = rst ? '0 : r_cmd.wdata;
  assign mem_read_type  = rst ? '0 : r_cmd.rt;
  assign mem_write_type = rst ? '0 : r_cmd.wt;

  assign busy = !rst && (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter.
// Random traffic is checked against a transaction-level schedule model.
module tb_mem_bus_arbiter;

  localparam int SM = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rt;
    logic [1:0]  wt;
  } tcmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_read_type;
  logic [1:0]  m0_write_type;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_read_type;
  logic [1:0]  m1_write_type;
  logic [31:0] mem_addr, mem_din, dm_dout, mmio_dout;
  logic [2:0]  mem_read_type;
  logic [1:0]  mem_write_type;
  logic        dm_we, mmio_we, busy;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MMIO_PAGE  (8'h7f),
    .STARVE_MAX (SM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_read_type   (m0_read_type),
    .m0_write_type  (m0_write_type),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_read_type   (m1_read_type),
    .m1_write_type  (m1_write_type),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_read_type  (mem_read_type),
    .mem_write_type (mem_write_type),
    .dm_we          (dm_we),
    .mmio_we        (mmio_we),
    .dm_dout        (dm_dout),
    .mmio_dout      (mmio_dout),
    .busy           (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input tcmd_t c, input logic r);
    m0_req = r; m0_we = c.we; m0_addr = c.addr; m0_wdata = c.wdata;
    m0_read_type = c.rt; m0_write_type = c.wt;
  endtask

  task automatic set1(input tcmd_t c, input logic r);
    m1_req = r; m1_we = c.we; m1_addr = c.addr; m1_wdata = c.wdata;
    m1_read_type = c.rt; m1_write_type = c.wt;
  endtask

  function automatic tcmd_t mk(input logic we, input logic [31:0] a,
                               input logic [31:0] d);
    tcmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.rt = 3'd2; c.wt = 2'd2;
    return c;
  endfunction

  function automatic tcmd_t rnd_cmd();
    tcmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = $urandom;
    c.wdata = $urandom;
    c.rt    = 3'($urandom_range(0, 7));
    c.wt    = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) c.addr[15:8] = 8'h7f;
    else if (c.addr[15:8] == 8'h7f) c.addr[15:8] = 8'h00;
    return c;
  endfunction

  // Transaction-level expectations, indexed by cycle within an episode.
  tcmd_t       c0 [8];
  tcmd_t       c1 [8];
  int          eg   [48];
  int          erv  [48];
  bit          edm  [48];
  bit          emm  [48];
  bit          esrc [48];
  bit          ebsy [48];
  logic [31:0] eadr [48];
  logic [31:0] edin [48];

  initial begin
    tcmd_t c;
    int got, dual, n0, n1, i0, i1, t, cnt, w, end_t;
    logic [9:0] order;
    logic [31:0] ev, ov, er;

    rst = 1'b1;
    set0(mk(0, 0, 0), 0);
    set1(mk(0, 0, 0), 0);
    dm_dout = '0;
    mmio_dout = '0;
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_din", mem_din, 0);
    chk("post_rst_types", 32'({mem_read_type, mem_write_type}), 0);
    chk("post_rst_we", 32'({dm_we, mmio_we}), 0);
    tick;

    // m0 write to data memory
    set0(mk(1, 32'h0000_0010, 32'hDEAD_BEEF), 1);
    tick;
    chk("w0_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
    chk("w0_dm_we", 32'(dm_we), 1);
    chk("w0_mmio_we", 32'(mmio_we), 0);
    chk("w0_addr", mem_addr, 32'h0000_0010);
    chk("w0_din", mem_din, 32'hDEAD_BEEF);
    set0(mk(0, 0, 0), 0);
    tick;
    chk("w0_busy_after", 32'(busy), 0);
    chk("w0_we_after", 32'({dm_we, mmio_we}), 0);

    // m1 read from MMIO
    mmio_dout = 32'h0000_00A5;
    dm_dout = 32'h1111_1111;
    set1(mk(0, 32'h0000_7f04, 0), 1);
    tick;
    chk("r1_gnt", 32'({m0_gnt, m1_gnt}), 32'b01);
    chk("r1_we_issue", 32'({dm_we, mmio_we}), 0);
    set1(mk(0, 0, 0), 0);
    tick;
    chk("r1_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'b01);
    chk("r1_rdata", m1_rdata, 32'h0000_00A5);
    chk("r1_dm_we", 32'(dm_we), 0);
    tick;
    chk("r1_busy_after", 32'(busy), 0);
    chk("r1_rdata_idle", m1_rdata, 0);

    // back-to-back reads from both sources
    dm_dout = 32'h0D0D_0D0D;
    mmio_dout = 32'h0E0E_0E0E;
    set0(mk(0, 32'h0000_0020, 0), 1);
    tick;
    set0(mk(0, 0, 0), 0);
    tick;
    chk("rr_dm_data", m0_rdata, 32'h0D0D_0D0D);
    tick;
    set0(mk(0, 32'h0000_7f00, 0), 1);
    tick;
    chk("rr_gnt2", 32'(m0_gnt), 1);
    set0(mk(0, 0, 0), 0);
    tick;
    chk("rr_mmio_data", m0_rdata, 32'h0E0E_0E0E);
    tick;

    // simultaneous requests, count 0
    set0(mk(1, 32'h0000_0030, 32'h3), 1);
    set1(mk(1, 32'h0000_7f08, 32'h4), 1);
    tick;
    chk("sim_first", 32'({m0_gnt, m1_gnt}), 32'b10);
    chk("sim_first_dm", 32'(dm_we), 1);
    set0(mk(0, 0, 0), 0);
    tick;
    chk("sim_idle", 32'({m1_gnt, busy}), 0);
    tick;
    chk("sim_second", 32'({m0_gnt, m1_gnt}), 32'b01);
    chk("sim_second_we", 32'({dm_we, mmio_we}), 32'b01);
    chk("sim_second_addr", mem_addr, 32'h0000_7f08);
    set1(mk(0, 0, 0), 0);
    tick;
    tick;

    // starvation: both held
    set0(mk(1, 32'h0000_0040, 32'h5), 1);
    set1(mk(1, 32'h0000_0044, 32'h6), 1);
    got = 0;
    dual = 0;
    order = '0;
    for (int k = 0; k < 40 && got < 10; k++) begin
      tick;
      if (m0_gnt && m1_gnt) dual++;
      if (m0_gnt || m1_gnt) begin
        order[got] = m1_gnt;
        got++;
      end
    end
    chk("starve_count", 32'(got), 10);
    chk("starve_order", 32'(order), 32'h210);
    chk("starve_dual", 32'(dual), 0);
    set0(mk(0, 0, 0), 0);
    set1(mk(0, 0, 0), 0);
    tick;
    tick;
    tick;

    // reset during ISSUE of a write
    set0(mk(1, 32'h0000_0050, 32'h1234), 1);
    tick;
    rst = 1'b1;
    #1;
    chk("rsti_gnt", 32'({m0_gnt, m1_gnt}), 0);
    chk("rsti_we", 32'({dm_we, mmio_we}), 0);
    chk("rsti_busy", 32'(busy), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rsti_idle", 32'({busy, m0_gnt}), 0);
    tick;
    chk("rsti_serve_gnt", 32'(m0_gnt), 1);
    chk("rsti_serve_we", 32'(dm_we), 1);
    chk("rsti_serve_din", mem_din, 32'h1234);
    set0(mk(0, 0, 0), 0);
    tick;

    // reset during RESP drops the read
    set0(mk(0, 32'h0000_0060, 0), 1);
    tick;
    set0(mk(0, 0, 0), 0);
    tick;
    rst = 1'b1;
    #1;
    chk("rstr_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    chk("rstr_rdata", m0_rdata, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rstr_after", 32'({busy, m0_rvalid}), 0);
    tick;
    tick;

    // randomized episodes against the schedule model
    for (int ep = 0; ep < 40; ep++) begin
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n1 = 1;
      for (int k = 0; k < 8; k++) begin
        c0[k] = rnd_cmd();
        c1[k] = rnd_cmd();
      end
      for (int k = 0; k < 48; k++) begin
        eg[k] = 0; erv[k] = 0; edm[k] = 0; emm[k] = 0;
        esrc[k] = 0; ebsy[k] = 0; eadr[k] = '0; edin[k] = '0;
      end
      t = 0; cnt = 0; i0 = 0; i1 = 0;
      while (i0 < n0 || i1 < n1) begin
        if (i0 < n0 && cnt < SM) w = 0;
        else if (i1 < n1) w = 1;
        else w = 0;
        c = (w == 1) ? c1[i1] : c0[i0];
        eg[t+1] = w + 1;
        ebsy[t+1] = 1;
        eadr[t+1] = c.addr;
        edin[t+1] = c.wdata;
        if (c.we) begin
          edm[t+1] = (c.addr[15:8] != 8'h7f);
          emm[t+1] = (c.addr[15:8] == 8'h7f);
        end else begin
          ebsy[t+2] = 1;
          erv[t+2] = w + 1;
          esrc[t+2] = (c.addr[15:8] == 8'h7f);
        end
        if (w == 0) begin
          if (i1 < n1) cnt = (cnt < SM) ? cnt + 1 : SM;
          else cnt = 0;
          i0++;
        end else begin
          cnt = 0;
          i1++;
        end
        t = t + (c.we ? 2 : 3);
      end
      end_t = t;
      i0 = 0; i1 = 0;
      for (int k = 0; k <= end_t; k++) begin
        dm_dout = $urandom;
        mmio_dout = $urandom;
        #1;
        ev = 32'({eg[k] == 1, eg[k] == 2, edm[k], emm[k],
                  erv[k] == 1, erv[k] == 2, ebsy[k]});
        ov = 32'({m0_gnt, m1_gnt, dm_we, mmio_we,
                  m0_rvalid, m1_rvalid, busy});
        chk("rnd_ctrl", ov, ev);
        er = esrc[k] ? mmio_dout : dm_dout;
        chk("rnd_rdata0", m0_rdata, (erv[k] == 1) ? er : 32'h0);
        chk("rnd_rdata1", m1_rdata, (erv[k] == 2) ? er : 32'h0);
        if (eg[k] != 0) begin
          chk("rnd_addr", mem_addr, eadr[k]);
          chk("rnd_din", mem_din, edin[k]);
        end
        if (m0_gnt) i0++;
        if (m1_gnt) i1++;
        set0(c0[i0 & 7], i0 < n0);
        set1(c1[i1 & 7], i1 < n1);
        tick;
      end
      set0(mk(0, 0, 0), 0);
      set1(mk(0, 0, 0), 0);
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
